// File: rtl/fanout_pkg.sv
// Shared defaults for the lane fork: lane width, fan-out, FIFO depth and
// the upstream slack derived from the fan-out.
package fanout_pkg;

    localparam int unsigned IN_W_DEF   = 1024;
    localparam int unsigned FANOUT_DEF = 3;
    localparam int unsigned DEPTH_DEF  = 8;

    // Upstream keeps issuing for one cycle per fanout stage plus the credit register.
    function automatic int unsigned slack_of(input int unsigned fanout);
        return fanout + 1;
    endfunction

endpackage

// File: rtl/bundle_fifo_ctrl.sv
// Pointer, occupancy and full/empty bookkeeping for the bundle FIFO.
// A push into a full FIFO is accepted only when the head pops the same cycle.
module bundle_fifo_ctrl #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned PTR_W = $clog2(DEPTH),
    parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    output logic [PTR_W-1:0] wr_ptr,
    output logic [PTR_W-1:0] rd_ptr,
    output logic [CNT_W-1:0] count_next_c,
    output logic             push_ok_c,
    output logic             empty_c
);

    logic [CNT_W-1:0] count;
    logic             full_c;
    logic             pop_ok_c;

    assign empty_c      = (count == '0);
    assign full_c       = (count == CNT_W'(DEPTH));
    assign pop_ok_c     = pop && !empty_c;
    assign push_ok_c    = push && (!full_c || pop_ok_c);
    assign count_next_c = count + CNT_W'(push_ok_c) - CNT_W'(pop_ok_c);

    // Power-of-two depth lets the pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok_c) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop_ok_c) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count_next_c;
        end
    end

endmodule

// File: rtl/fanout_lane_fork.sv
// Buffers whole bundles from a non-stalling upstream and forks each head
// bundle to FANOUT lanes that complete independently; pops once all lanes are served.
module fanout_lane_fork
    import fanout_pkg::*;
#(
    parameter int unsigned IN_W   = IN_W_DEF,
    parameter int unsigned FANOUT = FANOUT_DEF,
    parameter int unsigned DEPTH  = DEPTH_DEF,
    parameter int unsigned SLACK  = slack_of(FANOUT)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   up_vld,
    input  logic [FANOUT*IN_W-1:0] up_dat,
    output logic                   up_rdy,
    output logic [FANOUT-1:0]      dn_vld,
    input  logic [FANOUT-1:0]      dn_rdy,
    output logic [FANOUT*IN_W-1:0] dn_dat,
    output logic                   overflow
);

    localparam int unsigned BW    = FANOUT * IN_W;
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count_next_c;
    logic              push_ok_c;
    logic              empty_c;
    logic              pop_c;
    logic [FANOUT-1:0] served;
    logic [FANOUT-1:0] hs_c;
    logic [BW-1:0]     mem [DEPTH];

    bundle_fifo_ctrl #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W),
        .CNT_W (CNT_W)
    ) u_ctrl (
        .clk          (clk),
        .rst_n        (rst_n),
        .push         (up_vld),
        .pop          (pop_c),
        .wr_ptr       (wr_ptr),
        .rd_ptr       (rd_ptr),
        .count_next_c (count_next_c),
        .push_ok_c    (push_ok_c),
        .empty_c      (empty_c)
    );

    // A lane already served for the head entry is masked until the head pops.
    assign dn_vld = empty_c ? '0 : ~served;
    assign hs_c   = dn_vld & dn_rdy;
    assign pop_c  = !empty_c && (&(served | hs_c));
    assign dn_dat = mem[rd_ptr];

    // Storage is intentionally not reset; dn_dat is only meaningful with dn_vld.
    always_ff @(posedge clk) begin
        if (push_ok_c) begin
            mem[wr_ptr] <= up_dat;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            served   <= '0;
            overflow <= 1'b0;
            up_rdy   <= 1'b0;
        end else begin
            served   <= pop_c ? '0 : (served | hs_c);
            overflow <= overflow | (up_vld & ~push_ok_c);
            up_rdy   <= (CNT_W'(DEPTH) - count_next_c) > CNT_W'(SLACK);
        end
    end

endmodule

// File: tb/tb_fanout_lane_fork.sv
// Bench for fanout_lane_fork: hand-derived vector table, directed fill/overflow/reset
// sequences, and a randomized phase checked against a bundle scoreboard model.
module tb_fanout_lane_fork;

    localparam int unsigned IN_W   = 8;
    localparam int unsigned FANOUT = 3;
    localparam int unsigned DEPTH  = 8;
    localparam int unsigned SLACK  = 4;
    localparam int unsigned BW     = IN_W * FANOUT;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          up_vld;
    logic [BW-1:0] up_dat;
    logic          up_rdy;
    logic [2:0]    dn_vld;
    logic [2:0]    dn_rdy;
    logic [BW-1:0] dn_dat;
    logic          overflow;

    always #5 clk = ~clk;

    fanout_lane_fork #(
        .IN_W   (IN_W),
        .FANOUT (FANOUT),
        .DEPTH  (DEPTH),
        .SLACK  (SLACK)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .up_vld   (up_vld),
        .up_dat   (up_dat),
        .up_rdy   (up_rdy),
        .dn_vld   (dn_vld),
        .dn_rdy   (dn_rdy),
        .dn_dat   (dn_dat),
        .overflow (overflow)
    );

    int n_vec = 0;
    int n_bad = 0;

    // Scoreboard: accepted bundles in order, plus the expected lane/credit/flag state.
    logic [BW-1:0] sb_q[$];
    logic [2:0]    m_served = 3'b000;
    logic          m_ovf    = 1'b0;
    logic          m_uprdy  = 1'b0;

    typedef struct {
        logic          v;
        logic [BW-1:0] d;
        logic [2:0]    rdy;
        logic [2:0]    e_vld;
        logic [BW-1:0] e_dat;
        logic          e_uprdy;
        logic          e_ovf;
    } vec_t;

    vec_t tbl[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [2:0] m_vld();
        return (sb_q.size() > 0) ? ~m_served : 3'b000;
    endfunction

    function automatic logic [BW-1:0] mk(input int k);
        return {8'(8'h40 + k), 8'(8'h20 + k), 8'(8'h10 + k)};
    endfunction

    task automatic check_model(input string tag);
        logic [2:0] ev;
        ev = m_vld();
        chk($sformatf("%s.dn_vld", tag), 32'(dn_vld), 32'(ev));
        if (ev != 3'b000) chk($sformatf("%s.dn_dat", tag), 32'(dn_dat), 32'(sb_q[0]));
        chk($sformatf("%s.up_rdy", tag), 32'(up_rdy), 32'(m_uprdy));
        chk($sformatf("%s.overflow", tag), 32'(overflow), 32'(m_ovf));
    endtask

    // Advance the model by one clock using the inputs currently driven.
    task automatic model_step();
        logic [2:0] hs;
        logic       pop;
        logic       acc;
        if (rst_n) begin
            sb_q.delete();
            m_served = 3'b000;
            m_ovf    = 1'b0;
            m_uprdy  = 1'b0;
            return;
        end
        hs  = m_vld() & dn_rdy;
        pop = (sb_q.size() > 0) && ((m_served | hs) == 3'b111);
        acc = up_vld && ((sb_q.size() < int'(DEPTH)) || pop);
        if (up_vld && !acc) m_ovf = 1'b1;
        if (pop) void'(sb_q.pop_front());
        if (acc) sb_q.push_back(up_dat);
        m_served = pop ? 3'b000 : (m_served | hs);
        m_uprdy  = (int'(DEPTH) - sb_q.size()) > int'(SLACK);
    endtask

    task automatic drive(input logic r, input logic v, input logic [BW-1:0] d, input logic [2:0] rdy);
        rst_n  = r;
        up_vld = v;
        up_dat = d;
        dn_rdy = rdy;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        // Rows: inputs for the cycle, then outputs expected at the start of it.
        tbl[0] = '{1'b1, 24'h030201, 3'b111, 3'b000, 24'h000000, 1'b0, 1'b0};
        tbl[1] = '{1'b0, 24'h000000, 3'b111, 3'b111, 24'h030201, 1'b1, 1'b0};
        tbl[2] = '{1'b1, 24'h060504, 3'b011, 3'b000, 24'h000000, 1'b1, 1'b0};
        tbl[3] = '{1'b0, 24'h000000, 3'b011, 3'b111, 24'h060504, 1'b1, 1'b0};
        tbl[4] = '{1'b0, 24'h000000, 3'b011, 3'b100, 24'h060504, 1'b1, 1'b0};
        tbl[5] = '{1'b0, 24'h000000, 3'b011, 3'b100, 24'h060504, 1'b1, 1'b0};
        tbl[6] = '{1'b0, 24'h000000, 3'b111, 3'b100, 24'h060504, 1'b1, 1'b0};
        tbl[7] = '{1'b0, 24'h000000, 3'b111, 3'b000, 24'h000000, 1'b1, 1'b0};
        tbl[8] = '{1'b0, 24'h000000, 3'b000, 3'b000, 24'h000000, 1'b1, 1'b0};

        drive(1'b1, 1'b0, '0, 3'b000);
        @(negedge clk);
        tick();
        tick();
        chk("reset.dn_vld", 32'(dn_vld), 32'h0);
        chk("reset.up_rdy", 32'(up_rdy), 32'h0);
        chk("reset.overflow", 32'(overflow), 32'h0);

        // Single push / staggered lane completion.
        for (int i = 0; i < 9; i++) begin
            chk($sformatf("tbl%0d.dn_vld", i), 32'(dn_vld), 32'(tbl[i].e_vld));
            if (tbl[i].e_vld != 3'b000)
                chk($sformatf("tbl%0d.dn_dat", i), 32'(dn_dat), 32'(tbl[i].e_dat));
            chk($sformatf("tbl%0d.up_rdy", i), 32'(up_rdy), 32'(tbl[i].e_uprdy));
            chk($sformatf("tbl%0d.overflow", i), 32'(overflow), 32'(tbl[i].e_ovf));
            check_model($sformatf("tbl%0d", i));
            drive(1'b0, tbl[i].v, tbl[i].d, tbl[i].rdy);
            tick();
        end

        // Fill with all lanes stalled: credit drops after the 4th write.
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("fill%0d.up_rdy", k), 32'(up_rdy), (k < 4) ? 32'h1 : 32'h0);
            check_model($sformatf("fill%0d", k));
            drive(1'b0, 1'b1, mk(k), 3'b000);
            tick();
        end
        check_model("full");
        chk("full.head", 32'(dn_dat), 32'(mk(0)));
        chk("full.overflow", 32'(overflow), 32'h0);

        // Push and pop together while full.
        drive(1'b0, 1'b1, mk(8), 3'b111);
        tick();
        check_model("pushpop");
        chk("pushpop.overflow", 32'(overflow), 32'h0);
        chk("pushpop.head", 32'(dn_dat), 32'(mk(1)));

        // Push into a full FIFO with no pop is dropped and flagged.
        drive(1'b0, 1'b1, mk(9), 3'b000);
        tick();
        check_model("drop");
        chk("drop.overflow", 32'(overflow), 32'h1);
        chk("drop.head", 32'(dn_dat), 32'(mk(1)));
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, 1'b0, '0, 3'b000);
            tick();
            chk($sformatf("sticky%0d.overflow", k), 32'(overflow), 32'h1);
        end

        // Drain with random lane readiness; scoreboard checks order.
        for (int k = 0; k < 200 && sb_q.size() > 0; k++) begin
            check_model($sformatf("drain%0d", k));
            drive(1'b0, 1'b0, '0, 3'($urandom_range(0, 7)));
            tick();
        end
        chk("drain.done", 32'(sb_q.size()), 32'h0);
        chk("drain.dn_vld", 32'(dn_vld), 32'h0);

        // Mid-operation reset at count=5.
        for (int k = 0; k < 5; k++) begin
            drive(1'b0, 1'b1, mk(20 + k), 3'b000);
            tick();
        end
        drive(1'b0, 1'b0, '0, 3'b001);
        tick();
        check_model("pre_rst");
        drive(1'b1, 1'b0, '0, 3'b000);
        tick();
        chk("rst.dn_vld", 32'(dn_vld), 32'h0);
        chk("rst.overflow", 32'(overflow), 32'h0);
        chk("rst.up_rdy", 32'(up_rdy), 32'h0);
        drive(1'b0, 1'b0, '0, 3'b111);
        tick();
        chk("rst_rel.up_rdy", 32'(up_rdy), 32'h1);
        chk("rst_rel.dn_vld", 32'(dn_vld), 32'h0);

        // Randomized traffic with occasional resets.
        for (int k = 0; k < 600; k++) begin
            check_model($sformatf("rnd%0d", k));
            drive((k % 150) == 149, ($urandom_range(0, 99) < 45), BW'($urandom),
                  3'($urandom_range(0, 7)));
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
